debounce_sync: RTL and testbench

Input conditioning stage for asynchronous, bouncy level signals such as buttons, straps and external status pins. It synchronises `din_async` into the `clk` domain and accepts a level change only after the new value has been stable for `DEBOUNCE_CYCLES` consecutive cycles. It drives a clean registered level `dout`, which feeds the rising-edge detector directly downstream. It also counts rejected transitions (glitches) for diagnostics.

---
 rtl/sync_async_pkg.sv | 21 ++
 rtl/sync_ff.sv | 25 ++
 rtl/debounce_sync.sv | 111 +++++++++++
 tb/tb_debounce_sync.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sync_async_pkg.sv
// Shared definitions for the async-input conditioning group
// (debounce_sync, downstream edge detector, related blocks).
//   - 2-bit FSM state encodings for the debouncer
//   - glitch counter width
package sync_async_pkg;

  localparam int GLITCH_W = 8;

  localparam logic [1:0] ST_STABLE_LO = 2'd0;
  localparam logic [1:0] ST_CHK_HI    = 2'd1;
  localparam logic [1:0] ST_STABLE_HI = 2'd2;
  localparam logic [1:0] ST_CHK_LO    = 2'd3;

  typedef enum logic [1:0] {
    STABLE_LO = ST_STABLE_LO,
    CHK_HI    = ST_CHK_HI,
    STABLE_HI = ST_STABLE_HI,
    CHK_LO    = ST_CHK_LO
  } db_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level.
//   clk  : destination clock
//   rstn : async active-low reset, every flop loads RESET_VAL
//   d    : raw asynchronous input
//   q    : synchronised output (last stage)
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) chain <= {STAGES{RESET_VAL}};
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise and debounce an asynchronous level.
// A level change on the synchronised input is accepted only after it has
// been sampled at the new value on DEBOUNCE_CYCLES consecutive edges;
// aborted candidates are counted in a saturating glitch counter.
//   clk        : clock
//   rstn       : async active-low reset
//   din_async  : raw asynchronous level
//   clr_cnt    : synchronous clear of glitch_cnt (wins over an abort)
//   dout       : debounced level, registered
//   settling   : high while a candidate transition is being qualified
//   glitch_cnt : saturating count of aborted transitions
module debounce_sync
  import sync_async_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,   // 2..4
  parameter int   DEBOUNCE_CYCLES = 16,  // >= 2
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                din_async,
  input  logic                clr_cnt,
  output logic                dout,
  output logic                settling,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam db_state_e ST_RST = RESET_VAL ? STABLE_HI : STABLE_LO;

  logic s;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (din_async),
    .q    (s)
  );

  db_state_e     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          dout_d;
  logic          abort;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_RST;
      cnt   <= '0;
      dout  <= RESET_VAL;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      dout  <= dout_d;
    end
  end

  // Entering CHK_* already counts as the first matching sample, so the
  // qualifying edge is the one where cnt holds DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    dout_d  = dout;
    abort   = 1'b0;
    unique case (state)
      STABLE_LO: if (s) begin
        state_d = CHK_HI;
        cnt_d   = CW'(1);
      end
      CHK_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          abort   = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_d = STABLE_HI;
          dout_d  = 1'b1;
        end else begin
          cnt_d   = cnt + CW'(1);
        end
      end
      STABLE_HI: if (!s) begin
        state_d = CHK_LO;
        cnt_d   = CW'(1);
      end
      CHK_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          abort   = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_d = STABLE_LO;
          dout_d  = 1'b0;
        end else begin
          cnt_d   = cnt + CW'(1);
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  assign settling = (state == CHK_HI) || (state == CHK_LO);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        glitch_cnt <= '0;
    else if (clr_cnt)                 glitch_cnt <= '0;
    else if (abort && !(&glitch_cnt)) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
  end

endmodule

// File: tb/tb_debounce_sync.sv
module tb_debounce_sync;

  logic       clk = 1'b0;
  logic       rstn;
  logic       din_async;
  logic       clr_cnt;
  logic       dout;
  logic       settling;
  logic [7:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  debounce_sync #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_VAL       (1'b0)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .din_async  (din_async),
    .clr_cnt    (clr_cnt),
    .dout       (dout),
    .settling   (settling),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge and sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [7:0] bounce_pat;

  initial begin
    rstn      = 1'b0;
    din_async = 1'b0;
    clr_cnt   = 1'b0;
    #1;

    // reset held while input toggles
    for (int i = 0; i < 4; i++) begin
      din_async = ~din_async;
      step();
      check("rst_dout", {7'b0, dout}, 8'd0);
      check("rst_settling", {7'b0, settling}, 8'd0);
      check("rst_glitch", glitch_cnt, 8'd0);
    end
    din_async = 1'b0;
    step();
    rstn = 1'b1;
    steps(4);
    check("idle_dout", {7'b0, dout}, 8'd0);

    // clean rise: settling high after edges 3..5, dout after edge 6
    din_async = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("rise_settling_e%0d", e), {7'b0, settling}, (e >= 3 && e <= 5) ? 8'd1 : 8'd0);
      check($sformatf("rise_dout_e%0d", e), {7'b0, dout}, (e >= 6) ? 8'd1 : 8'd0);
    end
    check("rise_glitch", glitch_cnt, 8'd0);

    // clean fall
    din_async = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      check($sformatf("fall_dout_e%0d", e), {7'b0, dout}, (e >= 6) ? 8'd0 : 8'd1);
    end

    // bounce 1,1,1,0,1,1,1,1: FSM sees pattern[j] at edge j+3
    bounce_pat = 8'b1111_0111; // bit j = pattern[j]
    din_async = bounce_pat[0];
    for (int e = 1; e <= 10; e++) begin
      step();
      din_async = (e < 8) ? bounce_pat[e] : 1'b1;
      if (e == 5) check("bounce_glitch_pre", glitch_cnt, 8'd0);
      if (e == 6) begin
        check("bounce_glitch", glitch_cnt, 8'd1);
        check("bounce_settling_abort", {7'b0, settling}, 8'd0);
      end
      if (e == 9) check("bounce_dout_e9", {7'b0, dout}, 8'd0);
      if (e == 10) begin
        check("bounce_dout_e10", {7'b0, dout}, 8'd1);
        check("bounce_settling_e10", {7'b0, settling}, 8'd0);
      end
    end
    steps(2);
    check("bounce_glitch_final", glitch_cnt, 8'd1);

    // clear colliding with an abort in CHK_LO
    din_async = 1'b0;
    step();                 // edge 1
    din_async = 1'b1;
    step();                 // edge 2
    step();                 // edge 3: enter CHK_LO
    check("coll_settling", {7'b0, settling}, 8'd1);
    check("coll_glitch_pre", glitch_cnt, 8'd1);
    clr_cnt = 1'b1;
    step();                 // edge 4: abort + clear
    clr_cnt = 1'b0;
    check("coll_glitch", glitch_cnt, 8'd0);
    check("coll_dout", {7'b0, dout}, 8'd1);
    check("coll_settling_post", {7'b0, settling}, 8'd0);

    // return low
    din_async = 1'b0;
    steps(8);
    check("low_dout", {7'b0, dout}, 8'd0);
    check("low_glitch", glitch_cnt, 8'd0);

    // short pulses: 10 first, then 290 more to saturate
    for (int i = 0; i < 300; i++) begin
      din_async = 1'b1;
      step();
      check("pulse_dout_hi", {7'b0, dout}, 8'd0);
      din_async = 1'b0;
      step();
      check("pulse_dout_lo", {7'b0, dout}, 8'd0);
      if (i == 9) begin
        steps(4);
        check("pulse_glitch_10", glitch_cnt, 8'd10);
      end
    end
    steps(4);
    check("pulse_glitch_sat", glitch_cnt, 8'd255);
    check("pulse_dout_final", {7'b0, dout}, 8'd0);
    din_async = 1'b1;
    step();
    din_async = 1'b0;
    steps(4);
    check("pulse_glitch_hold", glitch_cnt, 8'd255);

    // plain clear
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_glitch", glitch_cnt, 8'd0);

    // reset mid-qualification
    din_async = 1'b1;
    steps(4);               // CHK_HI, cnt = 2
    check("midrst_settling_pre", {7'b0, settling}, 8'd1);
    rstn = 1'b0;
    #1;
    check("midrst_dout", {7'b0, dout}, 8'd0);
    check("midrst_settling", {7'b0, settling}, 8'd0);
    check("midrst_glitch", glitch_cnt, 8'd0);
    step();
    rstn = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      check($sformatf("midrst_settling_e%0d", e), {7'b0, settling}, (e >= 3 && e <= 5) ? 8'd1 : 8'd0);
      check($sformatf("midrst_dout_e%0d", e), {7'b0, dout}, (e >= 6) ? 8'd1 : 8'd0);
    end
    check("midrst_glitch_post", glitch_cnt, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
